sync_fifo: RTL and testbench

- Parameterised single-clock FIFO of typed entries with first-word-fall-through (FWFT) reads.
- Primary use is the instruction queue between the fetch frontend and the OoO backend.
- Each entry is one DTYPE value, e.g. the {instr, pc} fetch packet.
- Frontend stalls on full; backend pops via ren while !empty; a pipeline flush is applied through the reset input.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo.sv | 73 +++++++
 tb/tb_sync_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the instruction-queue FIFO.
// The fetch packet type is handed to sync_fifo through its DTYPE parameter.
package sync_fifo_pkg;

    // One fetch packet: instruction word plus the pc it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } instr_queue_t;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO of typed entries.
// Head entry is presented combinationally on rdata; rdata reads zero while empty.
// Reset (asynchronous, active-low) drops all entries by clearing the pointers only.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter type         DTYPE = logic [WIDTH-1:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  DTYPE                   wdata,
    input  logic                   ren,
    output DTYPE                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    DTYPE          mem_q [DEPTH];
    logic          push;
    logic          pop;

    // Status flags and accept decisions, all derived from the current pointers.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        count = wptr_q - rptr_q;
        // A push while full is dropped even if a pop frees a slot on the same edge.
        push  = wen && !full;
        pop   = ren && !empty;
    end

    // Pointer next-state; the extra MSB wraps naturally with the adder.
    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers; reset clears occupancy without touching storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; no reset so the array maps onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    // FWFT head; zero while empty so uninitialised storage never leaks out.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_q[rptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo carrying fetch packets, DEPTH=32.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int unsigned Depth = 32;

    logic         clk;
    logic         rst;
    logic         wen;
    instr_queue_t wdata;
    logic         ren;
    instr_queue_t rdata;
    logic         full;
    logic         empty;
    logic [5:0]   count;

    int unsigned  n_vec;
    int unsigned  n_bad;
    logic [63:0]  model_q [$];
    logic [63:0]  val;
    logic [63:0]  hold;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (Depth),
        .DTYPE (instr_queue_t)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .wdata (wdata),
        .ren   (ren),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pkt(input int unsigned i);
        return {i[31:0], 32'h0000_1000 + (i[31:0] << 2)};
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;

        // Reset and idle
        tick();
        tick();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst = 1'b1;
        tick();
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("pop_empty_count", 64'(count), 64'd0);
        check("pop_empty_empty", 64'(empty), 64'd1);

        // Single push, fall-through
        wen   = 1'b1;
        wdata = {32'h0000_0013, 32'h1ece_b000};
        tick();
        wen = 1'b0;
        check("one_empty", 64'(empty), 64'd0);
        check("one_count", 64'(count), 64'd1);
        check("one_rdata", rdata, 64'h0000_0013_1ece_b000);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("one_pop_empty", 64'(empty), 64'd1);
        check("one_pop_rdata", rdata, 64'd0);

        // Fill to full
        for (int i = 0; i < Depth; i++) begin
            wen   = 1'b1;
            wdata = pkt(i);
            tick();
        end
        wen = 1'b0;
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd32);
        check("fill_head", rdata, pkt(0));
        wen   = 1'b1;
        wdata = 64'hdead_beef_dead_beef;
        tick();
        check("ovf_count", 64'(count), 64'd32);
        check("ovf_head", rdata, pkt(0));
        // Overflowing push with a pop alongside: pop taken, push still dropped
        ren = 1'b1;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        check("ovf_rw_count", 64'(count), 64'd31);
        check("ovf_rw_full", 64'(full), 64'd0);
        for (int i = 1; i < Depth; i++) begin
            check("drain_data", rdata, pkt(i));
            ren = 1'b1;
            tick();
            ren = 1'b0;
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_count", 64'(count), 64'd0);

        // Steady push+pop at occupancy 5, crossing pointer wrap
        for (int i = 0; i < 5; i++) begin
            val = {32'ha000_0000 + i[31:0], 32'h5555_0000 ^ i[31:0]};
            model_q.push_back(val);
            wen   = 1'b1;
            wdata = val;
            tick();
        end
        for (int i = 5; i < 105; i++) begin
            val = {32'ha000_0000 + i[31:0], 32'h5555_0000 ^ i[31:0]};
            check("stream_data", rdata, model_q[0]);
            wen   = 1'b1;
            ren   = 1'b1;
            wdata = val;
            tick();
            void'(model_q.pop_front());
            model_q.push_back(val);
            check("stream_count", 64'(count), 64'd5);
        end
        wen = 1'b0;
        while (model_q.size() > 0) begin
            check("stream_tail", rdata, model_q[0]);
            ren = 1'b1;
            tick();
            void'(model_q.pop_front());
        end
        ren = 1'b0;
        check("stream_empty", 64'(empty), 64'd1);

        // Push and pop together while empty: only the push lands
        wen   = 1'b1;
        ren   = 1'b1;
        wdata = 64'h1234_5678_9abc_def0;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        check("rw_empty_count", 64'(count), 64'd1);
        check("rw_empty_rdata", rdata, 64'h1234_5678_9abc_def0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) begin
            wen   = 1'b1;
            wdata = pkt(100 + i);
            tick();
        end
        wen = 1'b0;
        check("pre_rst_count", 64'(count), 64'd7);
        #2;
        rst = 1'b0;
        #1;
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_count", 64'(count), 64'd0);
        check("arst_rdata", rdata, 64'd0);
        tick();
        rst = 1'b1;
        wen   = 1'b1;
        wdata = 64'hcafe_f00d_0bad_c0de;
        tick();
        wen = 1'b0;
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_rdata", rdata, 64'hcafe_f00d_0bad_c0de);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("post_rst_empty", 64'(empty), 64'd1);
        check("post_rst_zero", rdata, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
